// File: rtl/ccff_pkg.sv
// Shared types and CRC helpers for the configuration-chain loader.
// State encoding is fixed-width so it survives netlist-level debug unchanged.
package ccff_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_FETCH = 3'd2,
    ST_LO    = 3'd3,
    ST_HI    = 3'd4,
    ST_DONE  = 3'd5
  } ccff_state_e;

  localparam logic [15:0] CCFF_CRC_POLY = 16'h1021;
  localparam logic [15:0] CCFF_CRC_INIT = 16'hFFFF;

  // One MSB-first CRC-16-CCITT step for a single incoming bit.
  function automatic logic [15:0] ccff_crc_step(input logic [15:0] crc, input logic din);
    logic fb;
    fb = crc[15] ^ din;
    return {crc[14:0], 1'b0} ^ (fb ? CCFF_CRC_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/ccff_crc16.sv
// Bit-serial CRC-16-CCITT register: folds one bit per enable, clr re-seeds to init.
// Latency: result visible the cycle after en; no backpressure (en is a strobe).
import ccff_pkg::*;

module ccff_crc16 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        en,
  input  logic        din,
  output logic [15:0] crc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc <= CCFF_CRC_INIT;
    end else if (clr) begin
      crc <= CCFF_CRC_INIT;
    end else if (en) begin
      crc <= ccff_crc_step(crc, din);
    end
  end

endmodule

// File: rtl/ccff_loader.sv
// Serialises a byte stream MSB-first onto the fabric ccff chain with a divided prog_clk; optional readback CRC under CCFF_READBACK_EN.
// Latency: start to set_o is 1 cycle; backpressure: byte_ready_o only in FETCH, shifting pauses (prog_clk low) until a byte arrives.
import ccff_pkg::*;

module ccff_loader #(
  parameter int CHAIN_LEN  = 2048,
  parameter int CLK_DIV    = 2,
  parameter int SET_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_i,
  input  logic       abort_i,
  input  logic [7:0] byte_i,
  input  logic       byte_valid_i,
  output logic       byte_ready_o,
  output logic       ccff_head_o,
  output logic       prog_clk_o,
  output logic       set_o,
  input  logic       ccff_tail_i,
  output logic       busy_o,
  output logic       done_o
`ifdef CCFF_READBACK_EN
  ,
  output logic [15:0] crc_o
`endif
);

  localparam int CNT_MAX = (CLK_DIV > SET_CYCLES) ? CLK_DIV : SET_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int BC_W    = $clog2(CHAIN_LEN + 1);

  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] SET_LAST = CNT_W'(SET_CYCLES - 1);
  localparam logic [BC_W-1:0]  BIT_LAST = BC_W'(CHAIN_LEN - 1);

  ccff_state_e      state_q;
  ccff_state_e      state_d;
  logic [CNT_W-1:0] div_cnt;
  logic [BC_W-1:0]  bit_cnt;
  logic [6:0]       shreg;
  logic [2:0]       bit_idx;
  logic             phase_end;
  logic             clear_end;
  logic             take;

  assign phase_end = (div_cnt == DIV_LAST);
  assign clear_end = (div_cnt == SET_LAST);
  assign take      = byte_ready_o && byte_valid_i;

  always_comb begin
    state_d = state_q;
    if (abort_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  if (start_i) state_d = ST_CLEAR;
        ST_CLEAR: if (clear_end) state_d = ST_FETCH;
        ST_FETCH: if (take) state_d = ST_LO;
        ST_LO:    if (phase_end) state_d = ST_HI;
        ST_HI: begin
          if (phase_end) begin
            if (bit_cnt == BIT_LAST)   state_d = ST_DONE;
            else if (bit_idx == 3'd0)  state_d = ST_FETCH;
            else                       state_d = ST_LO;
          end
        end
        ST_DONE:  state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // Outputs are registered from the next state so each pin is a clean flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      div_cnt      <= '0;
      bit_cnt      <= '0;
      shreg        <= '0;
      bit_idx      <= '0;
      ccff_head_o  <= 1'b0;
      prog_clk_o   <= 1'b0;
      set_o        <= 1'b0;
      byte_ready_o <= 1'b0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
    end else begin
      state_q <= state_d;

      if (state_d != state_q) begin
        div_cnt <= '0;
      end else if (state_q inside {ST_CLEAR, ST_LO, ST_HI}) begin
        div_cnt <= div_cnt + 1'b1;
      end

      if (state_q == ST_CLEAR) begin
        bit_cnt <= '0;
      end else if (state_q == ST_HI && phase_end) begin
        bit_cnt <= bit_cnt + 1'b1;
      end

      // Head only moves on entry to LO, so it is steady across the whole LO/HI pair.
      if (state_q == ST_FETCH && state_d == ST_LO) begin
        shreg       <= byte_i[6:0];
        bit_idx     <= 3'd7;
        ccff_head_o <= byte_i[7];
      end else if (state_q == ST_HI && state_d == ST_LO) begin
        shreg       <= {shreg[5:0], 1'b0};
        bit_idx     <= bit_idx - 1'b1;
        ccff_head_o <= shreg[6];
      end

      set_o        <= (state_d == ST_CLEAR);
      prog_clk_o   <= (state_d == ST_HI);
      byte_ready_o <= (state_d == ST_FETCH);
      busy_o       <= (state_d != ST_IDLE);
      done_o       <= (state_d == ST_DONE);
    end
  end

`ifdef CCFF_READBACK_EN
  logic crc_en;
  logic crc_clr;

  // Tail is captured on the last LO cycle, i.e. just before prog_clk rises.
  assign crc_en  = (state_q == ST_LO) && phase_end;
  assign crc_clr = (state_q == ST_CLEAR);

  ccff_crc16 u_crc (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (crc_clr),
    .en    (crc_en),
    .din   (ccff_tail_i),
    .crc   (crc_o)
  );
`else
  logic unused_tail;
  assign unused_tail = ccff_tail_i;
`endif

endmodule
